// File: rtl/mioc_dram_pkg.sv
// rtl/mioc_dram_pkg.sv - shared state encodings and defaults for the MIOC DRAM sequencer
package mioc_dram_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ROW  = 3'd1,
    S_COL  = 3'd2,
    S_CAS  = 3'd3,
    S_RFSH = 3'd4,
    S_PRE  = 3'd5
  } seq_state_t;

  typedef enum logic [1:0] {
    A_CPU = 2'd0,
    A_REQ = 2'd1,
    A_DMA = 2'd2,
    A_REL = 2'd3
  } arb_state_t;

  localparam int T_PRE_DEF    = 1;
  localparam int RFC_BITS_DEF = 8;

endpackage

// File: rtl/mioc_bus_arb.sv
// rtl/mioc_bus_arb.sv - Z80/6801 bus handshake; grants only change while the sequencer is idle
module mioc_bus_arb
  import mioc_dram_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic dma_n,
  input  logic busak_n,
  input  logic seq_idle,
  output logic busrq_n,
  output logic addrbufen_n,
  output logic dma_gnt_n
);

  arb_state_t state, state_nx;
  logic       busak_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= A_CPU;
      busak_q <= 1'b1;
    end else begin
      state   <= state_nx;
      busak_q <= busak_n;
    end
  end

  // The acknowledge is staged once so the grant lands two edges after BUSAK_N is seen low.
  always_comb begin
    state_nx    = state;
    busrq_n     = 1'b1;
    addrbufen_n = 1'b0;
    dma_gnt_n   = 1'b1;
    unique case (state)
      A_CPU: begin
        if (!dma_n) state_nx = A_REQ;
      end
      A_REQ: begin
        busrq_n = 1'b0;
        if (dma_n) state_nx = A_REL;
        else if (!busak_q && seq_idle) state_nx = A_DMA;
      end
      A_DMA: begin
        busrq_n     = 1'b0;
        addrbufen_n = 1'b1;
        dma_gnt_n   = 1'b0;
        if (dma_n && seq_idle) state_nx = A_REL;
      end
      A_REL: begin
        addrbufen_n = 1'b1;
        if (busak_n) state_nx = A_CPU;
      end
      default: state_nx = A_CPU;
    endcase
  end

endmodule

// File: rtl/mioc_dram_seq.sv
// rtl/mioc_dram_seq.sv - DRAM RAS/CAS/MUX sequencer with RAS-only refresh, RA7 mux and bus arbiter
module mioc_dram_seq
  import mioc_dram_pkg::*;
#(
  parameter int T_PRE    = T_PRE_DEF,
  parameter int RFC_BITS = RFC_BITS_DEF
) (
  input  logic B_PHI,
  input  logic RST_N,
  input  logic BMREQ_N,
  input  logic BRFSH_N,
  input  logic BA15,
  input  logic BA14,
  input  logic BA7,
  input  logic DMA_N,
  input  logic BUSAK_N,
  output logic RAS_N,
  output logic CAS1_N,
  output logic CAS2_N,
  output logic MUX,
  output logic RA7,
  output logic BUSRQ_N,
  output logic ADDRBUFEN_N,
  output logic DMA_GNT_N
);

  // The IDLE cycle that follows PRE also counts toward RAS-high time.
  localparam logic [1:0] PRE_LAST = (T_PRE > 1) ? 2'(T_PRE - 2) : 2'd0;

  seq_state_t          state, state_nx;
  logic                bank;
  logic [1:0]          pre_cnt;
  logic [RFC_BITS-1:0] rfc;
  logic                seq_idle;

  always_ff @(posedge B_PHI or negedge RST_N) begin
    if (!RST_N) begin
      state   <= S_IDLE;
      bank    <= 1'b0;
      pre_cnt <= 2'd0;
      rfc     <= '0;
    end else begin
      state <= state_nx;
      if (state == S_IDLE && !BMREQ_N && BRFSH_N) bank <= BA15;
      if (state == S_PRE) pre_cnt <= pre_cnt + 2'd1;
      else pre_cnt <= 2'd0;
      if (state == S_RFSH && BMREQ_N) rfc <= rfc + {{(RFC_BITS-1){1'b0}}, 1'b1};
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: begin
        if (!BMREQ_N) state_nx = BRFSH_N ? S_ROW : S_RFSH;
      end
      S_ROW:  state_nx = S_COL;
      S_COL:  state_nx = S_CAS;
      S_CAS:  if (BMREQ_N) state_nx = S_PRE;
      S_RFSH: if (BMREQ_N) state_nx = S_PRE;
      S_PRE:  if (pre_cnt >= PRE_LAST) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Strobes decode straight from state so an async reset drops them at once.
  always_comb begin
    RAS_N  = 1'b1;
    MUX    = 1'b0;
    CAS1_N = 1'b1;
    CAS2_N = 1'b1;
    RA7    = BA7;
    unique case (state)
      S_ROW:  RAS_N = 1'b0;
      S_COL: begin
        RAS_N = 1'b0;
        MUX   = 1'b1;
      end
      S_CAS: begin
        RAS_N  = 1'b0;
        MUX    = 1'b1;
        CAS1_N = bank;
        CAS2_N = !bank;
      end
      S_RFSH: RAS_N = 1'b0;
      default: ;
    endcase
    if (state == S_RFSH) RA7 = rfc[RFC_BITS-1];
    else if (MUX) RA7 = BA14;
  end

  assign seq_idle = (state == S_IDLE) && BMREQ_N;

  mioc_bus_arb u_arb (
    .clk         (B_PHI),
    .rst_n       (RST_N),
    .dma_n       (DMA_N),
    .busak_n     (BUSAK_N),
    .seq_idle    (seq_idle),
    .busrq_n     (BUSRQ_N),
    .addrbufen_n (ADDRBUFEN_N),
    .dma_gnt_n   (DMA_GNT_N)
  );

endmodule

// File: tb/tb_mioc_dram_seq.sv
// tb/tb_mioc_dram_seq.sv - self-checking bench for mioc_dram_seq at T_PRE=1 and T_PRE=3
module tb_mioc_dram_seq;

  logic B_PHI = 1'b0;
  logic RST_N, BMREQ_N, BRFSH_N, BA15, BA14, BA7, DMA_N, BUSAK_N;
  logic [1:0] ras_n, cas1_n, cas2_n, mux, ra7, busrq_n, addrbufen_n, dma_gnt_n;

  int vectors = 0;
  int miscompares = 0;
  int rcount = 0;

  always #5 B_PHI = ~B_PHI;

  mioc_dram_seq #(.T_PRE(1), .RFC_BITS(8)) dut1 (
    .B_PHI(B_PHI), .RST_N(RST_N), .BMREQ_N(BMREQ_N), .BRFSH_N(BRFSH_N),
    .BA15(BA15), .BA14(BA14), .BA7(BA7), .DMA_N(DMA_N), .BUSAK_N(BUSAK_N),
    .RAS_N(ras_n[0]), .CAS1_N(cas1_n[0]), .CAS2_N(cas2_n[0]), .MUX(mux[0]),
    .RA7(ra7[0]), .BUSRQ_N(busrq_n[0]), .ADDRBUFEN_N(addrbufen_n[0]), .DMA_GNT_N(dma_gnt_n[0])
  );

  mioc_dram_seq #(.T_PRE(3), .RFC_BITS(8)) dut3 (
    .B_PHI(B_PHI), .RST_N(RST_N), .BMREQ_N(BMREQ_N), .BRFSH_N(BRFSH_N),
    .BA15(BA15), .BA14(BA14), .BA7(BA7), .DMA_N(DMA_N), .BUSAK_N(BUSAK_N),
    .RAS_N(ras_n[1]), .CAS1_N(cas1_n[1]), .CAS2_N(cas2_n[1]), .MUX(mux[1]),
    .RA7(ra7[1]), .BUSRQ_N(busrq_n[1]), .ADDRBUFEN_N(addrbufen_n[1]), .DMA_GNT_N(dma_gnt_n[1])
  );

  function automatic int tpre_of(int i);
    return (i == 0) ? 1 : 3;
  endfunction

  // Shortest RAS-high gap: T_PRE cycles, but never below PRE plus one IDLE cycle.
  function automatic int min_ras_high(int t);
    return (t > 1) ? t : 2;
  endfunction

  function automatic logic [4:0] strobes(int i);
    return {ras_n[i], mux[i], cas1_n[i], cas2_n[i], ra7[i]};
  endfunction

  function automatic logic [2:0] arb(int i);
    return {busrq_n[i], addrbufen_n[i], dma_gnt_n[i]};
  endfunction

  task automatic step();
    @(posedge B_PHI);
    #1;
  endtask

  task automatic test_reset();
    RST_N = 1'b0; BMREQ_N = 1'b1; BRFSH_N = 1'b1; DMA_N = 1'b1; BUSAK_N = 1'b1;
    BA15 = 1'b0; BA14 = 1'b0; BA7 = 1'b0;
    for (int r = 0; r < 4; r++) begin
      BA7 = 1'($urandom); BA14 = ~BA7;
      #3;
      for (int i = 0; i < 2; i++) begin
        vectors++;
        if (strobes(i) !== {4'b1011, BA7}) begin
          miscompares++;
          $display("FAIL reset_strobes dut%0d got %b want %b", i, strobes(i), {4'b1011, BA7});
        end
        vectors++;
        if (arb(i) !== 3'b101) begin
          miscompares++;
          $display("FAIL reset_arb dut%0d got %b want 101", i, arb(i));
        end
      end
      step();
    end
    @(negedge B_PHI);
    RST_N = 1'b1;
    rcount = 0;
    step();
  endtask

  task automatic test_read(int n);
    logic b15, cas_on, m;
    int len;
    logic [4:0] exp;
    for (int t = 0; t < n; t++) begin
      b15 = 1'($urandom);
      len = $urandom_range(3, 6);
      BA15 = b15; BMREQ_N = 1'b0; BRFSH_N = 1'b1;
      for (int k = 1; k <= len + 1; k++) begin
        if (k == len + 1) BMREQ_N = 1'b1;
        BA14 = 1'($urandom); BA7 = 1'($urandom);
        step();
        BA15 = 1'($urandom);
        #1;
        m = (k >= 2 && k <= len);
        cas_on = (k >= 3 && k <= len);
        exp = {!(k <= len), m, !(cas_on && !b15), !(cas_on && b15), m ? BA14 : BA7};
        for (int i = 0; i < 2; i++) begin
          vectors++;
          if (strobes(i) !== exp) begin
            miscompares++;
            $display("FAIL read dut%0d bank%0d len%0d edge%0d got %b want %b", i, b15, len, k, strobes(i), exp);
          end
        end
      end
      repeat (3) step();
    end
  endtask

  task automatic test_refresh(int n);
    logic msb;
    for (int r = 0; r < n; r++) begin
      BMREQ_N = 1'b0; BRFSH_N = 1'b0;
      BA7 = 1'($urandom); BA14 = 1'($urandom);
      msb = ((rcount % 256) >= 128);
      for (int c = 0; c < 2; c++) begin
        step();
        for (int i = 0; i < 2; i++) begin
          vectors++;
          if (strobes(i) !== {4'b0011, msb}) begin
            miscompares++;
            $display("FAIL refresh%0d dut%0d got %b want %b", rcount, i, strobes(i), {4'b0011, msb});
          end
        end
      end
      BMREQ_N = 1'b1; BRFSH_N = 1'b1;
      step();
      rcount++;
      for (int i = 0; i < 2; i++) begin
        vectors++;
        if (strobes(i) !== {4'b1011, BA7}) begin
          miscompares++;
          $display("FAIL refresh_end%0d dut%0d got %b want %b", rcount, i, strobes(i), {4'b1011, BA7});
        end
      end
      repeat (2) step();
    end
  endtask

  task automatic test_reset_mid_cas();
    BA15 = 1'($urandom); BMREQ_N = 1'b0; BRFSH_N = 1'b1;
    repeat (3) step();
    #2;
    RST_N = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      vectors++;
      if (strobes(i) !== {4'b1011, BA7}) begin
        miscompares++;
        $display("FAIL reset_mid_cas dut%0d got %b want %b", i, strobes(i), {4'b1011, BA7});
      end
    end
    BMREQ_N = 1'b1;
    @(negedge B_PHI);
    RST_N = 1'b1;
    rcount = 0;
    step();
    BMREQ_N = 1'b0; BRFSH_N = 1'b0;
    step();
    for (int i = 0; i < 2; i++) begin
      vectors++;
      if (ra7[i] !== 1'b0) begin
        miscompares++;
        $display("FAIL counter_after_reset dut%0d ra7 got %b want 0", i, ra7[i]);
      end
    end
    BMREQ_N = 1'b1; BRFSH_N = 1'b1;
    step();
    rcount++;
    repeat (3) step();
  endtask

  task automatic test_back_to_back();
    int cnt[2];
    logic done[2];
    BA15 = 1'($urandom); BMREQ_N = 1'b0; BRFSH_N = 1'b1;
    repeat (4) step();
    BMREQ_N = 1'b1;
    step();
    BMREQ_N = 1'b0;
    for (int i = 0; i < 2; i++) begin
      cnt[i] = ras_n[i] ? 1 : 0;
      done[i] = !ras_n[i];
    end
    for (int c = 0; c < 10; c++) begin
      step();
      for (int i = 0; i < 2; i++) begin
        if (!done[i]) begin
          if (ras_n[i]) cnt[i]++;
          else done[i] = 1'b1;
        end
      end
    end
    for (int i = 0; i < 2; i++) begin
      vectors++;
      if (cnt[i] !== min_ras_high(tpre_of(i))) begin
        miscompares++;
        $display("FAIL back_to_back dut%0d ras_high got %0d want %0d", i, cnt[i], min_ras_high(tpre_of(i)));
      end
    end
    BMREQ_N = 1'b1;
    repeat (4) step();
  endtask

  task automatic test_dma();
    logic [2:0] exp;
    DMA_N = 1'b0; BUSAK_N = 1'b1;
    step();
    exp = 3'b001;
    for (int c = 0; c < 8; c++) begin
      if (c == 3) BUSAK_N = 1'b0;
      if (c == 5) exp = 3'b010;
      for (int i = 0; i < 2; i++) begin
        vectors++;
        if (arb(i) !== exp) begin
          miscompares++;
          $display("FAIL dma_grant dut%0d cycle%0d got %b want %b", i, c, arb(i), exp);
        end
      end
      step();
    end
    DMA_N = 1'b1;
    step();
    for (int c = 0; c < $urandom_range(1, 3); c++) begin
      for (int i = 0; i < 2; i++) begin
        vectors++;
        if (arb(i) !== 3'b111) begin
          miscompares++;
          $display("FAIL dma_release dut%0d got %b want 111", i, arb(i));
        end
      end
      step();
    end
    BUSAK_N = 1'b1;
    step();
    for (int i = 0; i < 2; i++) begin
      vectors++;
      if (arb(i) !== 3'b101) begin
        miscompares++;
        $display("FAIL dma_return dut%0d got %b want 101", i, arb(i));
      end
    end
    DMA_N = 1'b0;
    step();
    DMA_N = 1'b1;
    step();
    for (int i = 0; i < 2; i++) begin
      vectors++;
      if (arb(i) !== 3'b111) begin
        miscompares++;
        $display("FAIL dma_abort dut%0d got %b want 111", i, arb(i));
      end
    end
    step();
    for (int i = 0; i < 2; i++) begin
      vectors++;
      if (arb(i) !== 3'b101) begin
        miscompares++;
        $display("FAIL dma_abort_return dut%0d got %b want 101", i, arb(i));
      end
    end
  endtask

  task automatic test_dma_vs_cycle();
    logic b15;
    int hold;
    int lat[2];
    b15 = 1'($urandom);
    BA15 = b15; BMREQ_N = 1'b0; BRFSH_N = 1'b1;
    repeat (3) step();
    DMA_N = 1'b0; BUSAK_N = 1'b0;
    hold = $urandom_range(3, 5);
    for (int c = 0; c < hold; c++) begin
      step();
      for (int i = 0; i < 2; i++) begin
        vectors++;
        if ({dma_gnt_n[i], ras_n[i], cas1_n[i], cas2_n[i]} !== {2'b10, b15, !b15}) begin
          miscompares++;
          $display("FAIL dma_in_cas dut%0d got %b want %b", i,
                   {dma_gnt_n[i], ras_n[i], cas1_n[i], cas2_n[i]}, {2'b10, b15, !b15});
        end
      end
    end
    BMREQ_N = 1'b1;
    lat[0] = 0; lat[1] = 0;
    for (int c = 1; c <= 12; c++) begin
      step();
      for (int i = 0; i < 2; i++)
        if (lat[i] == 0 && !dma_gnt_n[i]) lat[i] = c;
    end
    for (int i = 0; i < 2; i++) begin
      vectors++;
      if (lat[i] !== min_ras_high(tpre_of(i)) + 1) begin
        miscompares++;
        $display("FAIL dma_after_cas dut%0d latency got %0d want %0d", i, lat[i], min_ras_high(tpre_of(i)) + 1);
      end
    end
    DMA_N = 1'b1;
    step();
    BUSAK_N = 1'b1;
    repeat (2) step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_read(12);
    test_refresh(384);
    test_reset_mid_cas();
    test_back_to_back();
    test_dma();
    test_dma_vs_cycle();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
